imap_rd_sched: RTL and testbench
================================

Name: imap_rd_sched

Overview:
- Read-side scheduler for the input feature map buffer.
- Walks a 3x3-convolution window schedule over one stored feature map and issues the buffer read strobes and addresses (imap_ren / imap_raddr).
- Tags each returned 64-bit word with window position flags for the MAC array.
- Sits between the layer controller (start/config) and the imap buffer read port; paces reads with mac_ready.

Parameters:
AW, 32, address width (matches buffer read address)
DIM_W, 10, width of map width/height config fields
CG_W, 8, width of channel-group count field

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle job start pulse; sampled only in IDLE
cfg_base  in  AW  word address of channel group 0, row 0, col 0
cfg_w  in  DIM_W  map width in words (columns)
cfg_h  in  DIM_W  map height in rows
cfg_cg  in  CG_W  number of channel groups (8 ch per 64-bit word)
mac_ready  in  1  MAC array can accept a word one cycle later
imap_ren  out  1  buffer read enable
imap_raddr  out  AW  buffer read address
imap_dvld  out  1  imap_rdata valid this cycle
imap_ky  out  2  kernel row (0..2) of the word on imap_rdata
imap_xfirst  out  1  word is column 0 of its row
imap_xlast  out  1  word is column cfg_w-1 of its row
imap_olast  out  1  final word of the job
busy  out  1  job in progress (CHECK, RUN or DRAIN)
done  out  1  one-cycle completion pulse
cfg_err  out  1  illegal config; valid with done

Behaviour:
- Reset values: imap_ren=0, imap_raddr=0, imap_dvld=0, imap_ky=0, all flags=0, busy=0, done=0, cfg_err=0, FSM=IDLE.
- Reset mid-job aborts immediately. In-flight read tags are dropped. No done pulse is produced.
- FSM states: IDLE, CHECK, RUN, DRAIN.
- IDLE: on start, latch cfg_*, go to CHECK. While not IDLE, start is ignored.
- CHECK (1 cycle): if cfg_w==0, cfg_h<3 or cfg_cg==0, assert done=1 and cfg_err=1 for one cycle, issue no reads, go to IDLE. Otherwise clear counters and go to RUN.
- Loop order, outermost to innermost: cg 0..cfg_cg-1, oy 0..cfg_h-3, ky 0..2, x 0..cfg_w-1.
- Address: raddr = cfg_base + cg*cfg_h*cfg_w + (oy+ky)*cfg_w + x, modulo 2^AW.
- The address is generated incrementally with running row-base registers. No multipliers.
- RUN: in a cycle with mac_ready=1, assert imap_ren with the current address and advance the counters.
- RUN with mac_ready=0: imap_ren=0, counters hold, imap_raddr holds its last value.
- Read latency is 1. imap_dvld and the tags (ky, xfirst, xlast, olast) are registered copies of the issue cycle, aligned with imap_rdata one cycle after imap_ren.
- The MAC array must consume every dvld word unconditionally. The ready-to-data latency is exactly 1.
- When the final read is issued (all counters at their maxima), go to DRAIN.
- DRAIN (1 cycle): imap_dvld=1 with imap_olast=1, done=1, cfg_err=0, then IDLE.
- Total reads per job = cfg_cg*(cfg_h-2)*3*cfg_w.
- cfg_w==1: xfirst and xlast are both 1 on every word.
- Counter wrap: x wraps to 0 and increments ky; ky wraps after 2 and increments oy; oy wraps after cfg_h-3 and increments cg.
- busy=1 from the cycle after start through the DRAIN cycle, or through the CHECK cycle on an error.
- imap_ren is never asserted outside RUN.

Decomposition:
- Shared package holds: FSM state encoding (IDLE/CHECK/RUN/DRAIN), the KSIZE=3 constant, and the read-latency constant (1).
- One natural sub-module: imap_addr_gen. It contains the nested counters and incremental address registers, with step/last outputs.
- The FSM, tag pipeline and handshake stay in the top module.

Test Plan:
- Basic: base=0x100, W=4, H=3, CG=1, mac_ready=1 -> 12 consecutive ren with addresses 0x100..0x10B. dvld one cycle later with ky 0,0,0,0,1,...,2. xfirst at x=0, xlast at x=3. olast and done together on the 12th dvld.
- Multi-row/group: W=2, H=4, CG=2, base=0 -> 24 reads.
  - Read 7 (first of oy=1) address = 2.
  - Read 13 (first of cg=1) address = 8.
  - Last address = 15.
- Backpressure: basic job with mac_ready low on cycles 3-5 of RUN -> ren low and raddr held during the stall. The address sequence is unchanged, dvld gaps mirror the stall, and done is delayed by 3 cycles.
- Illegal config: H=2 (and separately W=0, CG=0) -> done=1 and cfg_err=1 two cycles after start, with zero ren.
- Start while busy: second start pulse during RUN is ignored; the read count stays 12.
- Reset mid-RUN: assert rst after 5 reads -> next cycle all outputs are 0 with no done. A new start then runs a full 12-read job from 0x100.

Source files
------------

// File: rtl/imap_rd_sched_pkg.sv
// Shared definitions for the imap read scheduler: FSM encoding, window size,
// buffer read latency and the per-word tag carried alongside the read data.
package imap_rd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int KSIZE  = 3;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic       vld;
    logic [1:0] ky;
    logic       xfirst;
    logic       xlast;
    logic       olast;
  } tag_t;

endpackage

// File: rtl/imap_addr_gen.sv
// Nested cg/oy/ky/x window counters with running row-base registers; the read
// address is the current row base plus x, so no multiplier is needed.
module imap_addr_gen
  import imap_rd_sched_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DIM_W = 10,
  parameter int CG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_init,
  input  logic             i_step,
  input  logic [AW-1:0]    i_base,
  input  logic [DIM_W-1:0] i_w,
  input  logic [DIM_W-1:0] i_h,
  input  logic [CG_W-1:0]  i_cg,
  output logic [AW-1:0]    o_addr,
  output logic [1:0]       o_ky,
  output logic             o_xfirst,
  output logic             o_xlast,
  output logic             o_last
);

  logic [DIM_W-1:0] r_x;
  logic [DIM_W-1:0] r_oy;
  logic [1:0]       r_ky;
  logic [CG_W-1:0]  r_cg;
  logic [AW-1:0]    r_row;
  logic [AW-1:0]    r_win;

  logic          w_x_last;
  logic          w_ky_last;
  logic          w_oy_last;
  logic          w_cg_last;
  logic [AW-1:0] w_w_ext;

  assign w_w_ext   = AW'(i_w);
  assign w_x_last  = (r_x == i_w - DIM_W'(1));
  assign w_ky_last = (r_ky == 2'(KSIZE - 1));
  assign w_oy_last = (r_oy == i_h - DIM_W'(KSIZE));
  assign w_cg_last = (r_cg == i_cg - CG_W'(1));

  assign o_addr   = r_row + AW'(r_x);
  assign o_ky     = r_ky;
  assign o_xfirst = (r_x == '0);
  assign o_xlast  = w_x_last;
  assign o_last   = w_x_last & w_ky_last & w_oy_last & w_cg_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x   <= '0;
      r_oy  <= '0;
      r_ky  <= '0;
      r_cg  <= '0;
      r_row <= '0;
      r_win <= '0;
    end else if (i_init) begin
      r_x   <= '0;
      r_oy  <= '0;
      r_ky  <= '0;
      r_cg  <= '0;
      r_row <= i_base;
      r_win <= i_base;
    end else if (i_step) begin
      if (!w_x_last) begin
        r_x <= r_x + DIM_W'(1);
      end else begin
        r_x <= '0;
        if (!w_ky_last) begin
          r_ky  <= r_ky + 2'd1;
          r_row <= r_row + w_w_ext;
        end else begin
          r_ky <= '0;
          if (!w_oy_last) begin
            r_oy  <= r_oy + DIM_W'(1);
            r_win <= r_win + w_w_ext;
            r_row <= r_win + w_w_ext;
          end else begin
            // Last window row is h-1, so one more row lands on the next group's row 0
            r_oy  <= '0;
            r_cg  <= r_cg + CG_W'(1);
            r_win <= r_row + w_w_ext;
            r_row <= r_row + w_w_ext;
          end
        end
      end
    end
  end

endmodule

// File: rtl/imap_rd_sched.sv
// Read-side scheduler for the input feature map buffer: walks the 3x3 window
// schedule, issues paced reads and tags each returned word for the MAC array.
module imap_rd_sched
  import imap_rd_sched_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DIM_W = 10,
  parameter int CG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    cfg_base,
  input  logic [DIM_W-1:0] cfg_w,
  input  logic [DIM_W-1:0] cfg_h,
  input  logic [CG_W-1:0]  cfg_cg,
  input  logic             mac_ready,
  output logic             imap_ren,
  output logic [AW-1:0]    imap_raddr,
  output logic             imap_dvld,
  output logic [1:0]       imap_ky,
  output logic             imap_xfirst,
  output logic             imap_xlast,
  output logic             imap_olast,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  state_t           r_state;
  logic [AW-1:0]    r_base;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_h;
  logic [CG_W-1:0]  r_cg;
  logic [AW-1:0]    r_last_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic          w_issue;
  logic          w_cfg_bad;
  logic [AW-1:0] w_addr;
  logic [1:0]    w_ky;
  logic          w_xfirst;
  logic          w_xlast;
  logic          w_last;
  tag_t          w_tag_in;
  tag_t          w_tag_out;

  assign w_issue   = (r_state == ST_RUN) & mac_ready;
  assign w_cfg_bad = (r_w == '0) | (r_h < DIM_W'(KSIZE)) | (r_cg == '0);

  imap_addr_gen #(
    .AW    (AW),
    .DIM_W (DIM_W),
    .CG_W  (CG_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_init   (r_state == ST_CHECK),
    .i_step   (w_issue),
    .i_base   (r_base),
    .i_w      (r_w),
    .i_h      (r_h),
    .i_cg     (r_cg),
    .o_addr   (w_addr),
    .o_ky     (w_ky),
    .o_xfirst (w_xfirst),
    .o_xlast  (w_xlast),
    .o_last   (w_last)
  );

  // Ready gates the strobe directly so the word arrives exactly one cycle after ready
  assign imap_ren   = w_issue;
  assign imap_raddr = w_issue ? w_addr : r_last_addr;

  assign w_tag_in = w_issue ? '{vld: 1'b1, ky: w_ky, xfirst: w_xfirst,
                                xlast: w_xlast, olast: w_last} : '0;

  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
    tag_t r_stage;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) r_stage <= '0;
        else     r_stage <= w_tag_in;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) r_stage <= '0;
        else     r_stage <= g_tag[gi-1].r_stage;
      end
    end
  end

  assign w_tag_out   = g_tag[RD_LAT-1].r_stage;
  assign imap_dvld   = w_tag_out.vld;
  assign imap_ky     = w_tag_out.ky;
  assign imap_xfirst = w_tag_out.xfirst;
  assign imap_xlast  = w_tag_out.xlast;
  assign imap_olast  = w_tag_out.olast;

  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_cg        <= '0;
      r_last_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base  <= cfg_base;
            r_w     <= cfg_w;
            r_h     <= cfg_h;
            r_cg    <= cfg_cg;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_cfg_bad) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_last_addr <= w_addr;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imap_rd_sched.sv
// Scoreboard bench for imap_rd_sched: a loop-nest reference model fills expected
// read/tag/done queues; a monitor pops and compares whatever the DUT presents.
module tb_imap_rd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] cfg_base;
  logic [9:0]  cfg_w;
  logic [9:0]  cfg_h;
  logic [7:0]  cfg_cg;
  logic        mac_ready;
  logic        imap_ren;
  logic [31:0] imap_raddr;
  logic        imap_dvld;
  logic [1:0]  imap_ky;
  logic        imap_xfirst;
  logic        imap_xlast;
  logic        imap_olast;
  logic        busy;
  logic        done;
  logic        cfg_err;

  imap_rd_sched #(.AW(32), .DIM_W(10), .CG_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_base    (cfg_base),
    .cfg_w       (cfg_w),
    .cfg_h       (cfg_h),
    .cfg_cg      (cfg_cg),
    .mac_ready   (mac_ready),
    .imap_ren    (imap_ren),
    .imap_raddr  (imap_raddr),
    .imap_dvld   (imap_dvld),
    .imap_ky     (imap_ky),
    .imap_xfirst (imap_xfirst),
    .imap_xlast  (imap_xlast),
    .imap_olast  (imap_olast),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ky;
    logic       xf;
    logic       xl;
    logic       ol;
  } exp_tag_t;

  logic [31:0] rd_q[$];
  exp_tag_t    tag_q[$];
  logic        done_q[$];

  int          n_pass = 0;
  int          n_chk  = 0;
  int          n_ren  = 0;
  bit          prev_ren = 1'b0;
  bit          job_issued = 1'b0;
  logic [31:0] last_addr = 32'h0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: enumerate the schedule straight from the loop order and address formula
  task automatic gen_model(input logic [31:0] base, input int w, input int h, input int cg,
                           output int nexp, output bit bad);
    exp_tag_t t;
    nexp = 0;
    bad  = (w == 0) || (h < 3) || (cg == 0);
    if (!bad) begin
      for (int c = 0; c < cg; c++)
        for (int oy = 0; oy <= h - 3; oy++)
          for (int ky = 0; ky < 3; ky++)
            for (int x = 0; x < w; x++) begin
              rd_q.push_back(base + 32'(c * h * w + (oy + ky) * w + x));
              t.ky = 2'(ky);
              t.xf = (x == 0);
              t.xl = (x == w - 1);
              t.ol = (c == cg - 1) && (oy == h - 3) && (ky == 2) && (x == w - 1);
              tag_q.push_back(t);
              nexp++;
            end
    end
    done_q.push_back(bad);
  endtask

  task automatic flush_model();
    rd_q.delete();
    tag_q.delete();
    done_q.delete();
    prev_ren  = 1'b0;
    last_addr = 32'h0;
  endtask

  // Monitor: compares every presented read, data word and done pulse against the queues
  initial begin
    exp_tag_t t;
    logic     e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (imap_ren) begin
        n_ren++;
        job_issued = 1'b1;
        if (rd_q.size() == 0) chk("extra_ren", imap_ren, 0);
        else chk("raddr", imap_raddr, rd_q.pop_front());
        chk("ren_busy", busy, 1);
        last_addr = imap_raddr;
      end else if (busy && job_issued && rd_q.size() > 0) begin
        chk("stall_hold", imap_raddr, last_addr);
      end
      if (imap_dvld || prev_ren) chk("dvld_latency", imap_dvld, prev_ren);
      if (imap_dvld) begin
        if (tag_q.size() == 0) chk("extra_dvld", imap_dvld, 0);
        else begin
          t = tag_q.pop_front();
          chk("ky", imap_ky, t.ky);
          chk("xfirst", imap_xfirst, t.xf);
          chk("xlast", imap_xlast, t.xl);
          chk("olast", imap_olast, t.ol);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("extra_done", done, 0);
        else begin
          e = done_q.pop_front();
          chk("cfg_err", cfg_err, e);
          chk("done_olast", imap_olast, !e);
        end
      end
      prev_ren = imap_ren;
    end
  end

  // mode 0: always ready, 1: ready low where mask bit set, 2: random ready
  task automatic run_job(input logic [31:0] base, input int w, input int h, input int cg,
                         input int mode, input logic [63:0] mask, input int exp_lat,
                         input bit restart);
    int nexp;
    bit bad;
    int r0;
    int cyc;
    bit got;
    gen_model(base, w, h, cg, nexp, bad);
    r0 = n_ren;
    @(posedge clk); #1;
    cfg_base   = base;
    cfg_w      = 10'(w);
    cfg_h      = 10'(h);
    cfg_cg     = 8'(cg);
    start      = 1'b1;
    job_issued = 1'b0;
    cyc = 0;
    got = 1'b0;
    mac_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !mask[0] : ($urandom_range(0, 9) < 7);
    while (!got && cyc < 3000) begin
      @(negedge clk);
      if (done) got = 1'b1;
      if (!got) begin
        @(posedge clk); #1;
        cyc++;
        start = restart && (cyc == 5);
        if (start) cfg_base = $urandom;
        mac_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !mask[cyc % 64] :
                    ($urandom_range(0, 9) < 7);
      end
    end
    chk("done_seen", got, 1);
    if (exp_lat >= 0) chk("done_latency", cyc, exp_lat);
    @(posedge clk); #1;
    start     = 1'b0;
    mac_ready = 1'b0;
    chk("read_count", n_ren - r0, nexp);
    chk("busy_after_done", busy, 0);
    $display("job base=0x%08h w=%0d h=%0d cg=%0d mode=%0d reads=%0d cycles=%0d err=%0d",
             base, w, h, cg, mode, n_ren - r0, cyc, bad);
    if (!got) flush_model();
  endtask

  initial begin
    int nexp;
    bit bad;
    int r0;
    int k;
    rst = 1'b1; start = 1'b0; mac_ready = 1'b0;
    cfg_base = '0; cfg_w = '0; cfg_h = '0; cfg_cg = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ren", imap_ren, 0);     chk("rst_raddr", imap_raddr, 0);
    chk("rst_dvld", imap_dvld, 0);   chk("rst_ky", imap_ky, 0);
    chk("rst_xfirst", imap_xfirst, 0); chk("rst_xlast", imap_xlast, 0);
    chk("rst_olast", imap_olast, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);        chk("rst_cfg_err", cfg_err, 0);

    run_job(32'h100, 4, 3, 1, 0, 64'h0, 14, 1'b0);          // basic
    run_job(32'h0, 2, 4, 2, 0, 64'h0, 26, 1'b0);            // multi-row / group
    run_job(32'h100, 4, 3, 1, 1, 64'h70, 17, 1'b0);         // stall on RUN cycles 3-5
    run_job(32'h100, 4, 2, 1, 0, 64'h0, 2, 1'b0);           // H=2
    run_job(32'h100, 0, 3, 1, 0, 64'h0, 2, 1'b0);           // W=0
    run_job(32'h100, 4, 3, 0, 0, 64'h0, 2, 1'b0);           // CG=0
    run_job(32'h100, 4, 3, 1, 0, 64'h0, 14, 1'b1);          // start while busy
    run_job(32'h20, 1, 5, 2, 0, 64'h0, 20, 1'b0);           // W=1
    run_job(32'hFFFF_FFF0, 4, 3, 2, 0, 64'h0, 26, 1'b0);    // address wrap

    // Reset in the middle of RUN
    gen_model(32'h100, 4, 3, 1, nexp, bad);
    r0 = n_ren;
    @(posedge clk); #1;
    cfg_base = 32'h100; cfg_w = 10'd4; cfg_h = 10'd3; cfg_cg = 8'd1;
    start = 1'b1; mac_ready = 1'b1; job_issued = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (n_ren - r0 < 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("pre_reset_reads", n_ren - r0, 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    flush_model();
    mac_ready = 1'b0;
    @(negedge clk);
    chk("abort_ren", imap_ren, 0);   chk("abort_raddr", imap_raddr, 0);
    chk("abort_dvld", imap_dvld, 0); chk("abort_olast", imap_olast, 0);
    chk("abort_busy", busy, 0);      chk("abort_done", done, 0);
    $display("reset mid-run after %0d reads", n_ren - r0);
    run_job(32'h100, 4, 3, 1, 0, 64'h0, 14, 1'b0);

    for (int j = 0; j < 12; j++) begin
      run_job($urandom, $urandom_range(1, 6), $urandom_range(3, 6), $urandom_range(1, 3),
              2, 64'h0, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
